noise_gen_v2: RTL and testbench

//  Parametrised PSG noise channel: rate divider, configurable-tap LFSR, volume gating.

---
 rtl/noise_gen_v2_pkg.sv | 53 +++++
 rtl/noise_gen_v2_if.sv | 47 ++++
 rtl/noise_gen_v2_lfsr.sv | 48 ++++
 rtl/noise_gen_v2.sv | 143 ++++++++++++++
 tb/tb_noise_gen_v2.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/noise_gen_v2_pkg.sv
// noise_gen_v2 shared definitions: rate codes, rate periods, chip variants.
// Variant tap/feedback tables are used when NOISE_VARIANT_SEL_EN is defined.
package noise_pkg;

    typedef enum logic [1:0] {
        NF_32    = 2'd0,
        NF_64    = 2'd1,
        NF_128   = 2'd2,
        NF_TONE3 = 2'd3
    } nf_rate_e;

    localparam int RATE_P0 = 32;
    localparam int RATE_P1 = 64;
    localparam int RATE_P2 = 128;

    typedef enum logic [1:0] {
        VAR_SMS     = 2'd0,
        VAR_SG      = 2'd1,
        VAR_TANDY   = 2'd2,
        VAR_SMS_ALT = 2'd3
    } variant_e;

    localparam int VAR_LFSR_W = 16;

    localparam logic [VAR_LFSR_W-1:0] TAPS_SMS   = 16'h0009;
    localparam logic [VAR_LFSR_W-1:0] TAPS_SG    = 16'h0003;
    localparam logic [VAR_LFSR_W-1:0] TAPS_TANDY = 16'h0011;

    localparam int FB_SMS   = 15;
    localparam int FB_SG    = 14;
    localparam int FB_TANDY = 14;

    function automatic logic [VAR_LFSR_W-1:0] variant_taps(variant_e v);
        logic [VAR_LFSR_W-1:0] t;
        case (v)
            VAR_SG:    t = TAPS_SG;
            VAR_TANDY: t = TAPS_TANDY;
            default:   t = TAPS_SMS;
        endcase
        return t;
    endfunction

    function automatic int variant_fb(variant_e v);
        int f;
        case (v)
            VAR_SG:    f = FB_SG;
            VAR_TANDY: f = FB_TANDY;
            default:   f = FB_SMS;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/noise_gen_v2_if.sv
// noise_gen_v2 bus: tick, control write, tone3 period, level in; noise out.
// The variant signal exists only when NOISE_VARIANT_SEL_EN is defined.
interface noise_gen_v2_if #(
    parameter int COUNTER_BITS = 10,
    parameter int VALUE_BITS   = 4
);
    logic                    clk_en;
    logic                    ctrl_wr;
    logic [2:0]              ctrl_data;
    logic [COUNTER_BITS-1:0] tone3_freq;
    logic [VALUE_BITS-1:0]   value;
`ifdef NOISE_VARIANT_SEL_EN
    logic [1:0]              variant;
`endif
    logic                    out_bit;
    logic [VALUE_BITS-1:0]   out_level;
    logic                    shift_strobe;

    modport master (
`ifdef NOISE_VARIANT_SEL_EN
        output variant,
`endif
        output clk_en,
        output ctrl_wr,
        output ctrl_data,
        output tone3_freq,
        output value,
        input  out_bit,
        input  out_level,
        input  shift_strobe
    );

    modport slave (
`ifdef NOISE_VARIANT_SEL_EN
        input  variant,
`endif
        input  clk_en,
        input  ctrl_wr,
        input  ctrl_data,
        input  tone3_freq,
        input  value,
        output out_bit,
        output out_level,
        output shift_strobe
    );

endinterface

// File: rtl/noise_gen_v2_lfsr.sv
// noise_lfsr: shift register with runtime tap mask and feedback position.
// Reseed loads a single one-hot bit; it wins over a same-cycle shift.
module noise_lfsr #(
    parameter int LFSR_BITS = 16,
    parameter int FBW       = 4,
    parameter int RESET_BIT = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 reseed,
    input  logic [FBW-1:0]       seed_bit,
    input  logic                 shift,
    input  logic                 white,
    input  logic [LFSR_BITS-1:0] tap_mask,
    input  logic [FBW-1:0]       fb_bit,
    output logic [LFSR_BITS-1:0] state
);

    logic [LFSR_BITS-1:0] lfsr_q;
    logic [LFSR_BITS-1:0] lfsr_d;
    logic [LFSR_BITS-1:0] fb_hot;
    logic [LFSR_BITS-1:0] low_mask;
    logic                 fb;

    // next state: reseed, else shift right with feedback into fb_bit
    always_comb begin
        fb_hot         = '0;
        fb_hot[fb_bit] = 1'b1;
        low_mask       = fb_hot - LFSR_BITS'(1);
        fb             = white ? ^(lfsr_q & tap_mask) : lfsr_q[0];
        lfsr_d         = lfsr_q;
        if (reseed) begin
            lfsr_d           = '0;
            lfsr_d[seed_bit] = 1'b1;
        end else if (shift) begin
            lfsr_d = ((lfsr_q >> 1) & low_mask) | (fb ? fb_hot : '0);
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (!reset_n) lfsr_q <= LFSR_BITS'(1) << RESET_BIT;
        else          lfsr_q <= lfsr_d;
    end

    assign state = lfsr_q;

endmodule

// File: rtl/noise_gen_v2.sv
// noise_gen_v2: PSG noise channel - rate divider, tap LFSR, volume gating.
// Define NOISE_VARIANT_SEL_EN for runtime chip-variant tap selection.
module noise_gen_v2
    import noise_pkg::*;
#(
    parameter int                   LFSR_BITS    = 16,
    parameter int                   COUNTER_BITS = 10,
    parameter int                   VALUE_BITS   = 4,
    parameter logic [LFSR_BITS-1:0] TAP_MASK     = 16'h0009,
    parameter int                   FEEDBACK_BIT = 15
) (
    input  logic          clk,
    input  logic          reset_n,
    noise_gen_v2_if.slave bus
);

    localparam int CW  = COUNTER_BITS + 2;
    localparam int FBW = $clog2(LFSR_BITS);
`ifdef NOISE_VARIANT_SEL_EN
    localparam int RST_BIT = FB_SMS;
`else
    localparam int RST_BIT = FEEDBACK_BIT;
`endif

    logic [2:0]            ctrl_q, ctrl_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  strobe_q, strobe_d;
    logic                  out_bit_q, out_bit_d;
    logic [VALUE_BITS-1:0] out_level_q, out_level_d;
`ifdef NOISE_VARIANT_SEL_EN
    variant_e              variant_q, variant_d;
`endif

    logic [CW-1:0]         period;
    logic                  wrap;
    logic                  shift;
    logic                  stuck;
    logic                  reseed;
    logic [LFSR_BITS-1:0]  lfsr_state;
    logic [LFSR_BITS-1:0]  tap_mask;
    logic [FBW-1:0]        fb_bit;
    logic [FBW-1:0]        new_fb_bit;
    logic [FBW-1:0]        seed_bit;

    // period decode from the latched rate code
    always_comb begin
        period = CW'(RATE_P0);
        case (nf_rate_e'(ctrl_q[1:0]))
            NF_32:    period = CW'(RATE_P0);
            NF_64:    period = CW'(RATE_P1);
            NF_128:   period = CW'(RATE_P2);
            NF_TONE3: period = (bus.tone3_freq == '0)
                             ? (CW'(1) << (COUNTER_BITS + 1))
                             : {1'b0, bus.tone3_freq, 1'b0};
            default:  period = CW'(RATE_P0);
        endcase
    end

    // tap and feedback selection for shifts and for reseeds
    always_comb begin
`ifdef NOISE_VARIANT_SEL_EN
        variant_d  = bus.ctrl_wr ? variant_e'(bus.variant) : variant_q;
        tap_mask   = LFSR_BITS'(variant_taps(variant_q));
        fb_bit     = FBW'(variant_fb(variant_q));
        new_fb_bit = FBW'(variant_fb(variant_e'(bus.variant)));
`else
        tap_mask   = TAP_MASK;
        fb_bit     = FBW'(FEEDBACK_BIT);
        new_fb_bit = FBW'(FEEDBACK_BIT);
`endif
    end

    // rate counter, control latch and shift decision
    always_comb begin
        ctrl_d = ctrl_q;
        cnt_d  = cnt_q;
        wrap   = (cnt_q >= (period - CW'(1)));
        shift  = bus.clk_en && wrap && !bus.ctrl_wr;
        stuck  = (lfsr_state == '0);
        if (bus.ctrl_wr) begin
            ctrl_d = bus.ctrl_data;
            cnt_d  = '0;
        end else if (bus.clk_en) begin
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
        end
        // an all-zero register would never leave zero; reload it instead
        reseed   = bus.ctrl_wr || (shift && stuck);
        seed_bit = bus.ctrl_wr ? new_fb_bit : fb_bit;
    end

    // output stage inputs
    always_comb begin
        strobe_d    = shift;
        out_bit_d   = lfsr_state[0];
        out_level_d = bus.value & {VALUE_BITS{lfsr_state[0]}};
    end

    // control, counter and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl_q      <= 3'b000;
            cnt_q       <= '0;
            strobe_q    <= 1'b0;
            out_bit_q   <= 1'b0;
            out_level_q <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            cnt_q       <= cnt_d;
            strobe_q    <= strobe_d;
            out_bit_q   <= out_bit_d;
            out_level_q <= out_level_d;
        end
    end

`ifdef NOISE_VARIANT_SEL_EN
    // latched chip variant
    always_ff @(posedge clk) begin
        if (!reset_n) variant_q <= VAR_SMS;
        else          variant_q <= variant_d;
    end
`endif

    noise_lfsr #(
        .LFSR_BITS (LFSR_BITS),
        .FBW       (FBW),
        .RESET_BIT (RST_BIT)
    ) u_lfsr (
        .clk      (clk),
        .reset_n  (reset_n),
        .reseed   (reseed),
        .seed_bit (seed_bit),
        .shift    (shift && !stuck),
        .white    (ctrl_q[2]),
        .tap_mask (tap_mask),
        .fb_bit   (fb_bit),
        .state    (lfsr_state)
    );

    assign bus.out_bit      = out_bit_q;
    assign bus.out_level    = out_level_q;
    assign bus.shift_strobe = strobe_q;

endmodule

// File: tb/tb_noise_gen_v2.sv
// tb_noise_gen_v2: directed stimulus, cycle model compare plus literal pins.
// Model tracks ticks-to-shift and LFSR value as plain integers.
module tb_noise_gen_v2;

    localparam int CB = 10;
    localparam int VB = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    noise_gen_v2_if #(.COUNTER_BITS(CB), .VALUE_BITS(VB)) bus ();

    noise_gen_v2 #(
        .LFSR_BITS    (16),
        .COUNTER_BITS (CB),
        .VALUE_BITS   (VB),
        .TAP_MASK     (16'h0009),
        .FEEDBACK_BIT (15)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    int      m_cyc = 0;
    bit      m_valid = 0;
    int      m_cnt = 0;
    int      m_lfsr = 0;
    bit [2:0] m_ctrl = 0;
    int      m_var = 0;
    bit      e_bit = 0;
    bit [VB-1:0] e_lvl = 0;
    bit      e_st = 0;

    bit obits[$];
    int st_cyc[$];
    bit st_prev = 0;

    function automatic int period_of(bit [2:0] c, int t3);
        case (c[1:0])
            2'd0:    return 32;
            2'd1:    return 64;
            2'd2:    return 128;
            default: return (t3 == 0) ? (2 << CB) : 2 * t3;
        endcase
    endfunction

    function automatic int fbpos(int v);
        return (v == 1 || v == 2) ? 14 : 15;
    endfunction

    function automatic int tapsof(int v);
        case (v)
            1:       return 'h0003;
            2:       return 'h0011;
            default: return 'h0009;
        endcase
    endfunction

    function automatic int next_state(int s, bit white, int v);
        int f;
        int fbv;
        f = fbpos(v);
        if (s == 0) return 1 << f;
        fbv = white ? ($countones(s & tapsof(v)) % 2) : (s % 2);
        return (s >> 1) | (fbv << f);
    endfunction

    // reference model advances on each rising edge
    always @(posedge clk) begin
        bit nb;
        bit [VB-1:0] nl;
        bit ns;
        m_cyc++;
        if (!reset_n) begin
            m_valid = 1;
            m_ctrl  = 0;
            m_cnt   = 0;
            m_var   = 0;
            m_lfsr  = 1 << 15;
            nb = 0;
            nl = 0;
            ns = 0;
        end else begin
            nb = (m_lfsr % 2) == 1;
            nl = nb ? bus.value : '0;
            ns = 0;
            if (bus.ctrl_wr) begin
                m_ctrl = bus.ctrl_data;
`ifdef NOISE_VARIANT_SEL_EN
                m_var = int'(bus.variant);
`else
                m_var = 0;
`endif
                m_cnt  = 0;
                m_lfsr = 1 << fbpos(m_var);
            end else if (bus.clk_en) begin
                if (m_cnt + 1 >= period_of(m_ctrl, int'(bus.tone3_freq))) begin
                    m_cnt  = 0;
                    m_lfsr = next_state(m_lfsr, m_ctrl[2], m_var);
                    ns = 1;
                end else begin
                    m_cnt++;
                end
            end
        end
        e_bit = nb;
        e_lvl = nl;
        e_st  = ns;
    end

    // per-cycle compare and strobe/bit monitor
    always @(negedge clk) begin
        if (m_valid) begin
            vectors++;
            if (bus.out_bit !== e_bit || bus.out_level !== e_lvl ||
                bus.shift_strobe !== e_st) begin
                miscompares++;
                $display("FAIL cycle %0d: bit/level/strobe got %b/%h/%b expected %b/%h/%b",
                         m_cyc, bus.out_bit, bus.out_level, bus.shift_strobe,
                         e_bit, e_lvl, e_st);
            end
            if (st_prev) obits.push_back(bus.out_bit);
            if (bus.shift_strobe === 1'b1) st_cyc.push_back(m_cyc);
            st_prev = (bus.shift_strobe === 1'b1);
        end
    end

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic wr(bit [2:0] d, output int edge_cyc);
        bus.ctrl_wr   = 1'b1;
        bus.ctrl_data = d;
        edge_cyc = m_cyc + 1;
        step(1);
        bus.ctrl_wr = 1'b0;
        obits.delete();
        st_cyc.delete();
    endtask

    initial begin
        int e;
        bit [19:0] v;
        int ones;
        bus.clk_en     = 1'b1;
        bus.ctrl_wr    = 1'b0;
        bus.ctrl_data  = 3'b000;
        bus.tone3_freq = '0;
        bus.value      = 4'hA;
`ifdef NOISE_VARIANT_SEL_EN
        bus.variant = 2'd0;
`endif
        reset_n = 1'b0;
        step(3);
        chk("reset out_bit", int'(bus.out_bit), 0);
        chk("reset out_level", int'(bus.out_level), 0);
        chk("reset strobe", int'(bus.shift_strobe), 0);
        reset_n = 1'b1;
        step(2);

        // white, N=32
        wr(3'b100, e);
        step(32 * 21 + 3);
        chk("white first strobe", st_cyc.size() > 0 ? st_cyc[0] - e : -1, 32);
        chk("white interval", st_cyc.size() > 1 ? st_cyc[1] - st_cyc[0] : -1, 32);
        chk("white bits captured", obits.size() >= 20, 1);
        v = '0;
        for (int i = 0; i < 20 && i < obits.size(); i++) v[i] = obits[i];
        chk("white first 20 bits", int'(v), 'h04000);

        // periodic, N=32: one high bit every 16 shifts
        wr(3'b000, e);
        step(64 * 32 + 40);
        ones = 0;
        for (int i = 0; i < 64 && i < obits.size(); i++) ones += int'(obits[i]);
        chk("periodic ones in 64", ones, 4);
        chk("periodic shift15", obits.size() > 15 ? int'(obits[14]) : -1, 1);
        chk("periodic shift16", obits.size() > 15 ? int'(obits[15]) : -1, 0);

        // tone3 rate
        bus.tone3_freq = 10'd5;
        wr(3'b011, e);
        step(40);
        chk("tone3=5 first", st_cyc.size() > 0 ? st_cyc[0] - e : -1, 10);
        chk("tone3=5 interval", st_cyc.size() > 1 ? st_cyc[1] - st_cyc[0] : -1, 10);

        bus.tone3_freq = 10'd0;
        wr(3'b111, e);
        step(2 * 2048 + 10);
        chk("tone3=0 first", st_cyc.size() > 0 ? st_cyc[0] - e : -1, 2048);
        chk("tone3=0 interval", st_cyc.size() > 1 ? st_cyc[1] - st_cyc[0] : -1, 2048);

        // shrink period below current count
        bus.tone3_freq = 10'd100;
        wr(3'b011, e);
        step(50);
        bus.tone3_freq = 10'd10;
        step(5);
        chk("shrink wrap", st_cyc.size() > 0 ? st_cyc[0] - e : -1, 51);

        // gated ticks with changing level
        wr(3'b100, e);
        for (int i = 0; i < 600; i++) begin
            bus.clk_en = 1'($urandom_range(0, 1));
            bus.value  = 4'($urandom_range(0, 15));
            step(1);
        end
        bus.clk_en = 1'b1;
        bus.value  = 4'hA;

        // reseed on the wrap cycle
        wr(3'b100, e);
        for (int i = 0; i < 40 && m_cnt != 31; i++) step(1);
        chk("reached wrap point", m_cnt, 31);
        wr(3'b101, e);
        chk("no strobe on reseed", int'(bus.shift_strobe), 0);
        step(70);
        chk("reseed first strobe", st_cyc.size() > 0 ? st_cyc[0] - e : -1, 64);

        // reset mid-run with a high output
        bus.value = 4'hF;
        wr(3'b000, e);
        step(482);
        chk("pre-reset level", int'(bus.out_level), 15);
        reset_n = 1'b0;
        step(1);
        chk("mid reset out_bit", int'(bus.out_bit), 0);
        chk("mid reset out_level", int'(bus.out_level), 0);
        chk("mid reset strobe", int'(bus.shift_strobe), 0);
        reset_n = 1'b1;
        step(3);

`ifdef NOISE_VARIANT_SEL_EN
        bus.variant = 2'd2;
        wr(3'b100, e);
        step(32 * 40);
        bus.variant = 2'd1;
        wr(3'b100, e);
        step(32 * 40);
        bus.variant = 2'd0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
